matmul_apb_slave: RTL and testbench

MATMUL_APB_SLAVE -- requirements
Module: matmul_apb_slave

---
 rtl/matmul_pkg.sv | 49 ++++
 rtl/matmul_operand_bank.sv | 38 +++
 rtl/matmul_apb_slave.sv | 170 +++++++++++++++++
 tb/tb_matmul_apb_slave.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-multiply APB register slave.
//   DATA_WIDTH / BUS_WIDTH / ADDR_WIDTH : element, APB data and APB address widths
//   MAX_DIM    : maximum matrix dimension, also the pstrb width (bytes per bus word)
//   LINE_WIDTH : width of the per-line index carried in paddr[5 +: LINE_WIDTH]
//   ADDR_*     : register offsets decoded on paddr[4:0]
//   apb_state_e: APB slave FSM states
//   apply_strobe: byte-lane merge used by every writable register
// ---------------------------------------------------------------------------
package matmul_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
  localparam int LINE_WIDTH = $clog2(MAX_DIM);

  localparam logic [4:0] ADDR_CONTROL   = 5'h00;
  localparam logic [4:0] ADDR_OPERAND_A = 5'h04;
  localparam logic [4:0] ADDR_OPERAND_B = 5'h08;
  localparam logic [4:0] ADDR_FLAGS     = 5'h0C;
  localparam logic [4:0] ADDR_SP        = 5'h10;

  // Bits of CONTROL that are actually stored: mode, write/read target and the
  // three dimension fields. Bit 0 (start) is a trigger and never stored.
  localparam logic [BUS_WIDTH-1:0] CONTROL_MASK = 32'h0000_3F3E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [BUS_WIDTH-1:0] apply_strobe(
    input logic [BUS_WIDTH-1:0] old_word,
    input logic [BUS_WIDTH-1:0] new_word,
    input logic [MAX_DIM-1:0]   strb
  );
    logic [BUS_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_DIM; b++) begin
      if (strb[b]) merged[b*DATA_WIDTH +: DATA_WIDTH] = new_word[b*DATA_WIDTH +: DATA_WIDTH];
    end
    return merged;
  endfunction

endpackage

// File: rtl/matmul_operand_bank.sv
// ---------------------------------------------------------------------------
// matmul_operand_bank
// MAX_DIM lines of BUS_WIDTH bits with a byte-strobed single-line write port.
// All lines are presented at once on a flattened bus for the compute core.
//   clk_i, rst_ni : clock, async active-low reset (clears every line)
//   we_i          : write enable for line line_i
//   line_i        : line index
//   strb_i        : byte-lane enables for the write
//   wdata_i       : write data
//   lines_o       : line i at lines_o[i*BUS_WIDTH +: BUS_WIDTH]
// ---------------------------------------------------------------------------
module matmul_operand_bank
  import matmul_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         we_i,
  input  logic [LINE_WIDTH-1:0]        line_i,
  input  logic [MAX_DIM-1:0]           strb_i,
  input  logic [BUS_WIDTH-1:0]         wdata_i,
  output logic [MAX_DIM*BUS_WIDTH-1:0] lines_o
);

  logic [BUS_WIDTH-1:0] mem [MAX_DIM];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_DIM; i++) mem[i] <= '0;
    end else if (we_i) begin
      mem[line_i] <= apply_strobe(mem[line_i], wdata_i, strb_i);
    end
  end

  for (genvar g = 0; g < MAX_DIM; g++) begin : g_flatten
    assign lines_o[g*BUS_WIDTH +: BUS_WIDTH] = mem[g];
  end

endmodule

// File: rtl/matmul_apb_slave.sv
// ---------------------------------------------------------------------------
// matmul_apb_slave
// APB register front-end for a matrix-multiply core. Transfers take one wait
// state: IDLE (master setup phase) -> SETUP (master enable phase) -> ACCESS
// (pready high). Read data and the error response are registered on entry to
// ACCESS; writes commit on the edge that leaves ACCESS.
//   clk_i, rst_ni                     : clock, async active-low reset
//   psel_i, penable_i, pwrite_i       : APB control
//   paddr_i                           : [4:0] register, [5 +: LINE_WIDTH] line
//   pwdata_i, pstrb_i                 : write data and byte-lane enables
//   pready_o, pslverr_o, prdata_o     : APB response
//   busy_o                            : core computation in progress
//   start_o                           : one-cycle start pulse to the core
//   control_o                         : stored CONTROL register
//   operand_a_o, operand_b_o          : flattened operand banks
//   done_i, flags_i                   : core completion and result flags
//   sp_addr_o, sp_data_i              : scratchpad line select / read data
// ---------------------------------------------------------------------------
module matmul_apb_slave
  import matmul_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [ADDR_WIDTH-1:0]        paddr_i,
  input  logic [BUS_WIDTH-1:0]         pwdata_i,
  input  logic [MAX_DIM-1:0]           pstrb_i,
  output logic                         pready_o,
  output logic                         pslverr_o,
  output logic [BUS_WIDTH-1:0]         prdata_o,
  output logic                         busy_o,
  output logic                         start_o,
  output logic [BUS_WIDTH-1:0]         control_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] operand_a_o,
  output logic [MAX_DIM*BUS_WIDTH-1:0] operand_b_o,
  input  logic                         done_i,
  input  logic [BUS_WIDTH-1:0]         flags_i,
  output logic [LINE_WIDTH-1:0]        sp_addr_o,
  input  logic [BUS_WIDTH-1:0]         sp_data_i
);

  apb_state_e           state;
  logic [4:0]           reg_sel;
  logic [LINE_WIDTH-1:0] line_sel;
  logic                 access_err;
  logic [BUS_WIDTH-1:0] read_data;
  logic [BUS_WIDTH-1:0] control_q;
  logic [BUS_WIDTH-1:0] flags_q;
  logic                 commit;
  logic                 we_a;
  logic                 we_b;
  logic                 we_ctrl;
  logic                 unused_addr_bits;

  assign reg_sel          = paddr_i[4:0];
  assign line_sel         = paddr_i[5 +: LINE_WIDTH];
  assign unused_addr_bits = ^paddr_i[ADDR_WIDTH-1:5+LINE_WIDTH];

  // Error and read-data decode, evaluated while the FSM sits in SETUP. The busy
  // check uses busy_o before the edge, so a write racing done_i still errors.
  always_comb begin
    access_err = 1'b0;
    read_data  = '0;
    case (reg_sel)
      ADDR_CONTROL:   read_data = control_q;
      ADDR_OPERAND_A: read_data = operand_a_o[int'(line_sel)*BUS_WIDTH +: BUS_WIDTH];
      ADDR_OPERAND_B: read_data = operand_b_o[int'(line_sel)*BUS_WIDTH +: BUS_WIDTH];
      ADDR_FLAGS:     read_data = flags_q;
      ADDR_SP:        read_data = sp_data_i;
      default:        access_err = 1'b1;
    endcase
    if (pwrite_i) begin
      if (reg_sel == ADDR_FLAGS || reg_sel == ADDR_SP) access_err = 1'b1;
      else if (busy_o) access_err = 1'b1;
    end
  end

  // The master holds address/data stable through ACCESS, so the live bus is
  // used at commit; an erroring transfer never commits.
  assign commit  = (state == ST_ACCESS) && pwrite_i && !pslverr_o;
  assign we_ctrl = commit && (reg_sel == ADDR_CONTROL);
  assign we_a    = commit && (reg_sel == ADDR_OPERAND_A);
  assign we_b    = commit && (reg_sel == ADDR_OPERAND_B);

  assign sp_addr_o = (state == ST_SETUP && reg_sel == ADDR_SP) ? line_sel : '0;
  assign control_o = control_q;

  // APB handshake FSM with registered response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
          prdata_o  <= '0;
          if (psel_i && !penable_i) state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (!psel_i) begin
            state <= ST_IDLE;
          end else if (penable_i) begin
            state     <= ST_ACCESS;
            pready_o  <= 1'b1;
            pslverr_o <= access_err;
            prdata_o  <= (access_err || pwrite_i) ? '0 : read_data;
          end
        end
        ST_ACCESS: begin
          state     <= ST_IDLE;
          pready_o  <= 1'b0;
          pslverr_o <= 1'b0;
          prdata_o  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // CONTROL, FLAGS and the core handshake. A start request clears FLAGS and
  // raises busy; busy drops (and FLAGS loads) on the edge that sees done_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      control_q <= '0;
      flags_q   <= '0;
      busy_o    <= 1'b0;
      start_o   <= 1'b0;
    end else begin
      start_o <= 1'b0;
      if (we_ctrl) begin
        control_q <= apply_strobe(control_q, pwdata_i, pstrb_i) & CONTROL_MASK;
        if (pwdata_i[0]) begin
          start_o <= 1'b1;
          busy_o  <= 1'b1;
          flags_q <= '0;
        end
      end else if (busy_o && done_i) begin
        busy_o  <= 1'b0;
        flags_q <= flags_i;
      end
    end
  end

  matmul_operand_bank u_bank_a (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (we_a),
    .line_i  (line_sel),
    .strb_i  (pstrb_i),
    .wdata_i (pwdata_i),
    .lines_o (operand_a_o)
  );

  matmul_operand_bank u_bank_b (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (we_b),
    .line_i  (line_sel),
    .strb_i  (pstrb_i),
    .wdata_i (pwdata_i),
    .lines_o (operand_b_o)
  );

endmodule

// File: tb/tb_matmul_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_matmul_apb_slave
// Self-checking bench for matmul_apb_slave. A behavioural model of the register
// file (arrays of words, a busy bit, a flags word) predicts every response.
// ---------------------------------------------------------------------------
module tb_matmul_apb_slave;
  import matmul_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0]  paddr = '0;
  logic [31:0]  pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic         pready, pslverr, busy, start;
  logic [31:0]  prdata, control;
  logic [127:0] operand_a, operand_b;
  logic         done = 1'b0;
  logic [31:0]  flags_in = '0;
  logic [1:0]   sp_addr;
  logic [31:0]  sp_data = '0;

  int pass_count = 0;
  int total_count = 0;
  int fail_count = 0;

  // Reference model state
  logic [31:0] model_a [4];
  logic [31:0] model_b [4];
  logic [31:0] model_ctrl;
  logic [31:0] model_flags;
  bit          model_busy;

  always #5 clk = ~clk;

  matmul_apb_slave dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .pstrb_i     (pstrb),
    .pready_o    (pready),
    .pslverr_o   (pslverr),
    .prdata_o    (prdata),
    .busy_o      (busy),
    .start_o     (start),
    .control_o   (control),
    .operand_a_o (operand_a),
    .operand_b_o (operand_b),
    .done_i      (done),
    .flags_i     (flags_in),
    .sp_addr_o   (sp_addr),
    .sp_data_i   (sp_data)
  );

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] pack_lines(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
    model_ctrl  = '0;
    model_flags = '0;
    model_busy  = 0;
  endfunction

  // Drive one APB transfer; optionally pulse done_i during the enable phase.
  task automatic apply_stimulus(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input bit pulse_done, input logic [31:0] done_flags,
                                output logic [31:0] rdata, output logic err, output int latency,
                                output logic [1:0] sp_seen);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    latency = 0; rdata = 'x; err = 'x;
    @(negedge clk);
    penable = 1'b1;
    sp_seen = sp_addr;
    if (pulse_done) begin
      done = 1'b1;
      flags_in = done_flags;
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      done = 1'b0;
      if (pready === 1'b1) begin
        latency = n + 3;
        rdata = prdata;
        err = pslverr;
        break;
      end
    end
    check_output("pready_cycle", latency, 3);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Transfer plus prediction from the model, then model update.
  task automatic run_transfer(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input bit pulse_done, input logic [31:0] done_flags);
    logic [31:0] rdata, exp_rdata;
    logic        err, exp_err;
    int          latency;
    logic [1:0]  sp_seen;
    logic [4:0]  sel;
    int          line;
    sel  = addr[4:0];
    line = int'(addr[6:5]);
    if (sel == 5'h10 && !wr) sp_data = data;
    exp_err = !(sel inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10});
    if (wr && (sel == 5'h0C || sel == 5'h10)) exp_err = 1'b1;
    if (wr && model_busy) exp_err = 1'b1;
    exp_rdata = '0;
    if (!exp_err && !wr) begin
      case (sel)
        5'h00:   exp_rdata = model_ctrl;
        5'h04:   exp_rdata = model_a[line];
        5'h08:   exp_rdata = model_b[line];
        5'h0C:   exp_rdata = model_flags;
        default: exp_rdata = data;
      endcase
    end
    apply_stimulus(wr, addr, data, strb, pulse_done, done_flags, rdata, err, latency, sp_seen);
    check_output("pslverr", err, exp_err);
    check_output("prdata", rdata, exp_rdata);
    if (sel == 5'h10 && !wr) check_output("sp_addr", sp_seen, addr[6:5]);
    if (pulse_done && model_busy) begin
      model_busy  = 0;
      model_flags = done_flags;
    end
    if (wr && !exp_err) begin
      case (sel)
        5'h04: model_a[line] = merge_bytes(model_a[line], data, strb);
        5'h08: model_b[line] = merge_bytes(model_b[line], data, strb);
        default: begin
          // Stored fields: mode[1], write tgt[3:2], read tgt[5:4], N-1[9:8], K-1[11:10], M-1[13:12]
          model_ctrl = merge_bytes(model_ctrl, data, strb) & 32'h0000_3F3E;
          if (data[0]) begin
            model_busy  = 1;
            model_flags = '0;
          end
        end
      endcase
    end
    check_output("operand_a", operand_a, pack_lines(model_a[0], model_a[1], model_a[2], model_a[3]));
    check_output("operand_b", operand_b, pack_lines(model_b[0], model_b[1], model_b[2], model_b[3]));
    check_output("control_o", control, model_ctrl);
    check_output("busy", busy, model_busy);
  endtask

  initial begin
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          op;

    model_reset();
    $display("[TB] reset and idle checks");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_pready", pready, 1'b0);
    check_output("rst_pslverr", pslverr, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_start", start, 1'b0);
    check_output("rst_prdata", prdata, 32'h0);
    check_output("rst_sp_addr", sp_addr, 2'd0);

    $display("[TB] operand write/read");
    run_transfer(1'b1, 16'h0044, 32'h0403_0201, 4'hF, 0, '0);
    check_output("opa_line2", operand_a[95:64], 32'h0403_0201);
    run_transfer(1'b0, 16'h0044, 32'h0, 4'h0, 0, '0);
    run_transfer(1'b1, 16'h0008, 32'hFFFF_FFFF, 4'b0101, 0, '0);
    check_output("opb_line0_strobe", operand_b[31:0], 32'h00FF_00FF);
    run_transfer(1'b0, 16'h0008, 32'h0, 4'h0, 0, '0);

    $display("[TB] randomized register traffic");
    for (int i = 0; i < 40; i++) begin
      op   = $urandom_range(0, 6);
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      addr = {9'd0, 2'($urandom_range(0, 3)), 5'h00};
      case (op)
        0: run_transfer(1'b1, addr | 16'h04, data, strb, 0, '0);
        1: run_transfer(1'b1, addr | 16'h08, data, strb, 0, '0);
        2: run_transfer(1'b0, addr | 16'h04, data, strb, 0, '0);
        3: run_transfer(1'b0, addr | 16'h08, data, strb, 0, '0);
        4: run_transfer(1'b1, 16'h0000, data & 32'hFFFF_FFFE, strb, 0, '0);
        5: run_transfer(1'b0, addr | 16'h10, data, strb, 0, '0);
        default: run_transfer(1'b0, 16'h0000, data, strb, 0, '0);
      endcase
    end

    $display("[TB] start and busy protection");
    run_transfer(1'b1, 16'h0000, 32'h0000_1501, 4'hF, 0, '0);
    check_output("start_pulse", start, 1'b1);
    check_output("busy_set", busy, 1'b1);
    @(negedge clk);
    check_output("start_single", start, 1'b0);
    run_transfer(1'b0, 16'h0000, 32'h0, 4'h0, 0, '0);
    check_output("ctrl_value", control, 32'h0000_1500);
    run_transfer(1'b1, 16'h0024, 32'hCAFE_BABE, 4'hF, 0, '0);
    run_transfer(1'b0, 16'h0024, 32'h0, 4'h0, 0, '0);

    $display("[TB] done handling");
    done = 1'b1; flags_in = 32'h5;
    model_busy = 0; model_flags = 32'h5;
    @(negedge clk);
    done = 1'b0;
    check_output("busy_cleared", busy, 1'b0);
    run_transfer(1'b0, 16'h000C, 32'h0, 4'h0, 0, '0);
    run_transfer(1'b1, 16'h000C, 32'h1234, 4'hF, 0, '0);
    done = 1'b1; flags_in = 32'h77;
    @(negedge clk);
    done = 1'b0;
    run_transfer(1'b0, 16'h000C, 32'h0, 4'h0, 0, '0);

    $display("[TB] control write racing done");
    run_transfer(1'b1, 16'h0000, 32'h0000_0103, 4'hF, 0, '0);
    run_transfer(1'b1, 16'h0000, 32'h0000_0002, 4'hF, 1, 32'hA);
    run_transfer(1'b0, 16'h000C, 32'h0, 4'h0, 0, '0);

    $display("[TB] invalid address and scratchpad");
    run_transfer(1'b0, 16'h0014, 32'h0, 4'h0, 0, '0);
    run_transfer(1'b1, 16'h0014, 32'h55, 4'hF, 0, '0);
    run_transfer(1'b0, 16'h0070, 32'h0000_DEAD, 4'h0, 0, '0);

    $display("[TB] reset during access");
    run_transfer(1'b1, 16'h0000, 32'h0000_0001, 4'hF, 0, '0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0024; pwdata = 32'h1111_2222; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check_output("mid_pready", pready, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("arst_pready", pready, 1'b0);
    check_output("arst_pslverr", pslverr, 1'b0);
    check_output("arst_busy", busy, 1'b0);
    check_output("arst_start", start, 1'b0);
    check_output("arst_prdata", prdata, 32'h0);
    check_output("arst_operand_a", operand_a, 128'h0);
    check_output("arst_control", control, 32'h0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_transfer(1'b1, 16'h0024, 32'h9ABC_DEF0, 4'hF, 0, '0);
    run_transfer(1'b0, 16'h0024, 32'h0, 4'h0, 0, '0);
    run_transfer(1'b0, 16'h000C, 32'h0, 4'h0, 0, '0);

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
